// File: rtl/darkroom_spi_pkg.sv
// Shared constants and the receive-FSM state type for the DarkRoom SPI frame receiver.
package darkroom_spi_pkg;

  localparam int FRAME_BYTES     = 32;
  localparam int WORDS_PER_FRAME = 8;
  localparam int BITS_PER_WORD   = 32;
  // Frame index width; sensor id = {frame_index, word_index} must fit in 8 bits.
  localparam int FRAME_INDEX_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_t;

  // Saturating 16-bit increment used by the error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/spi_slave_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the async SPI pins into clk, detects
// edges and shifts mosi MSB-first on each sck rise while selected.
module spi_slave_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       ss_high,
  output logic       selected,
  output logic       partial_bit
);

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] ss_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sck_prev_reg;
  logic                   ss_prev_reg;
  logic                   armed_reg;
  logic [2:0]             bit_cnt_reg;
  logic [6:0]             shift_reg;
  logic                   sck_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sample;

  assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
  assign ss_s   = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  // ss_n chain resets low so that a select still held low across reset produces
  // no falling edge; armed_reg only opens once ss_n has really been seen high.
  assign ss_fall     = ss_prev_reg & ~ss_s;
  assign ss_rise     = ~ss_prev_reg & ss_s;
  assign ss_high     = ss_s;
  assign selected    = armed_reg & ~ss_s;
  assign sample      = sck_s & ~sck_prev_reg & selected;
  assign partial_bit = (bit_cnt_reg != 3'd0);

  // Multi-stage synchronizers plus the previous-sample registers for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_reg  <= '0;
      ss_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      sck_prev_reg  <= 1'b0;
      ss_prev_reg   <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      sck_prev_reg  <= sck_s;
      ss_prev_reg   <= ss_s;
      if (ss_s) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // Bit shifter: clears on select, emits a one-cycle byte strobe on every 8th bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 7'd0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      if (ss_fall) begin
        bit_cnt_reg <= 3'd0;
      end else if (sample) begin
        shift_reg   <= {shift_reg[5:0], mosi_s};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift_reg, mosi_s};
        end
      end
    end
  end

endmodule

// File: rtl/darkroom_spi_frame_receiver.sv
// DarkRoom frame receiver: assembles 32-byte SPI frames into 8 little-endian
// 32-bit words, validates length, and streams committed frames out word by word.
module darkroom_spi_frame_receiver
  import darkroom_spi_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 8,
  parameter int BURST_GAP_CYCLES  = 4096,
  parameter int SYNC_STAGES       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_data_o,
  output logic [7:0]  word_sensor_id_o,
  output logic        word_last_o,
  output logic [15:0] frame_count_o,
  output logic [15:0] error_count_o,
  output logic        busy_o
);

  localparam int NUMBER_OF_SPI_FRAMES = (NUMBER_OF_SENSORS + WORDS_PER_FRAME - 1) / WORDS_PER_FRAME;
  localparam int GAP_W = $clog2(BURST_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(BURST_GAP_CYCLES);
  localparam logic [FRAME_INDEX_W-1:0] LAST_FRAME_INDEX = FRAME_INDEX_W'(NUMBER_OF_SPI_FRAMES - 1);

  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     ss_fall;
  logic                     ss_rise;
  logic                     ss_high;
  logic                     selected;
  logic                     partial_bit;

  rx_state_t                state_reg;
  logic [5:0]               byte_cnt_reg;
  logic                     long_reg;
  logic [23:0]              word_asm_reg;
  logic [BITS_PER_WORD-1:0] stage_mem [WORDS_PER_FRAME];
  logic [BITS_PER_WORD-1:0] out_mem [WORDS_PER_FRAME];
  logic                     out_valid_reg;
  logic [2:0]               out_idx_reg;
  logic [FRAME_INDEX_W-1:0] out_frame_reg;
  logic [BITS_PER_WORD-1:0] out_data_reg;
  logic [FRAME_INDEX_W-1:0] frame_idx_reg;
  logic [GAP_W-1:0]         gap_cnt_reg;
  logic [15:0]              frame_count_reg;
  logic [15:0]              error_count_reg;

  logic                     frame_good;
  logic                     transfer;
  logic                     buffer_free;
  logic                     commit;
  logic                     store_word;

  spi_slave_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck_i),
    .ss_n       (ss_n_i),
    .mosi       (mosi_i),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise),
    .ss_high    (ss_high),
    .selected   (selected),
    .partial_bit(partial_bit)
  );

  assign frame_good  = (byte_cnt_reg == 6'(FRAME_BYTES)) && !partial_bit && !long_reg;
  assign transfer    = out_valid_reg && word_ready_i;
  // The final transfer frees the buffer in the same cycle, so a commit may overlap it.
  assign buffer_free = !out_valid_reg || (transfer && (out_idx_reg == 3'd7));
  assign commit      = (state_reg == ST_CHECK) && frame_good && buffer_free;
  assign store_word  = (state_reg == ST_RECV) && byte_valid &&
                       (byte_cnt_reg < 6'(FRAME_BYTES)) && (byte_cnt_reg[1:0] == 2'd3);

  assign word_valid_o     = out_valid_reg;
  assign word_data_o      = out_data_reg;
  assign word_sensor_id_o = {out_frame_reg, out_idx_reg};
  assign word_last_o      = out_valid_reg && (out_idx_reg == 3'd7);
  assign frame_count_o    = frame_count_reg;
  assign error_count_o    = error_count_reg;
  assign busy_o           = selected;

  // Receive FSM with frame validation, counters, frame index and burst-gap tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      byte_cnt_reg    <= 6'd0;
      long_reg        <= 1'b0;
      word_asm_reg    <= 24'd0;
      frame_idx_reg   <= '0;
      gap_cnt_reg     <= '0;
      frame_count_reg <= 16'd0;
      error_count_reg <= 16'd0;
    end else begin
      if (ss_fall) begin
        gap_cnt_reg <= '0;
      end else if (ss_high && (gap_cnt_reg != GAP_LIMIT)) begin
        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
      end
      if (gap_cnt_reg == GAP_LIMIT) begin
        frame_idx_reg <= '0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (ss_fall) begin
            byte_cnt_reg <= 6'd0;
            long_reg     <= 1'b0;
            state_reg    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (ss_rise) begin
            state_reg <= ST_CHECK;
          end else if (byte_valid) begin
            if (byte_cnt_reg < 6'(FRAME_BYTES)) begin
              case (byte_cnt_reg[1:0])
                2'd0:    word_asm_reg[7:0]   <= byte_data;
                2'd1:    word_asm_reg[15:8]  <= byte_data;
                2'd2:    word_asm_reg[23:16] <= byte_data;
                default: ;
              endcase
              byte_cnt_reg <= byte_cnt_reg + 6'd1;
            end else begin
              long_reg <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          frame_idx_reg <= (frame_idx_reg == LAST_FRAME_INDEX) ? '0 : frame_idx_reg + FRAME_INDEX_W'(1);
          if (commit) begin
            frame_count_reg <= frame_count_reg + 16'd1;
          end else begin
            error_count_reg <= sat_inc16(error_count_reg);
          end
          if (ss_fall) begin
            byte_cnt_reg <= 6'd0;
            long_reg     <= 1'b0;
            state_reg    <= ST_RECV;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Staging write: every 4th byte completes a little-endian word.
  always_ff @(posedge clk) begin
    if (store_word) begin
      stage_mem[byte_cnt_reg[4:2]] <= {byte_data, word_asm_reg};
    end
  end

  // Output buffer snapshot of the staging words at commit.
  for (genvar gi = 0; gi < WORDS_PER_FRAME; gi++) begin : g_out_copy
    always_ff @(posedge clk) begin
      if (commit) begin
        out_mem[gi] <= stage_mem[gi];
      end
    end
  end

  // Output stream: registered word presentation, one word per accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_idx_reg   <= 3'd0;
      out_frame_reg <= '0;
      out_data_reg  <= '0;
    end else begin
      if (transfer) begin
        if (out_idx_reg == 3'd7) begin
          out_valid_reg <= 1'b0;
        end else begin
          out_idx_reg  <= out_idx_reg + 3'd1;
          out_data_reg <= out_mem[out_idx_reg + 3'd1];
        end
      end
      if (commit) begin
        out_valid_reg <= 1'b1;
        out_idx_reg   <= 3'd0;
        out_frame_reg <= frame_idx_reg;
        out_data_reg  <= stage_mem[0];
      end
    end
  end

endmodule
